// File: rtl/sram_adapter_pkg.sv
// Purpose : shared helpers and default sizing for the SRAM stream adapter.
// Contents: default parameter values, ceil_div / clog2_min1 helpers and the
//           response entry type at default width (rdata + write-ack flag).
// Optional feature macro used by this slice: SRAM_ADAPTER_WRITE_ACK_EN.
package sram_adapter_pkg;

  localparam int unsigned DEF_NUM_WORDS  = 1024;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_BYTE_WIDTH = 8;
  localparam int unsigned DEF_RSP_DEPTH  = 2;
  localparam int unsigned DEF_CNT_WIDTH  = $clog2(DEF_RSP_DEPTH + 1);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      write;
  } rsp_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_adapter_rsp_buf.sv
// Purpose : DEPTH-entry in-order FIFO holding responses that could not be
//           handed downstream in the cycle their read data arrived.
// Ports   : clk_i, rst_ni (async, active low)
//           push_i / data_i   write an entry at the tail
//           pop_i             drop the head entry
//           empty_o / head_o  occupancy flag and head entry
// The caller guarantees no push into a full buffer without a same-cycle pop.
module sram_adapter_rsp_buf
  import sram_adapter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_stream_adapter.sv
// Purpose : valid/ready request stream -> single-port SRAM strobes, with read
//           data returned on a valid/ready response stream. A credit counter
//           bounds in-flight + buffered responses to RSP_DEPTH so the SRAM
//           never has to stall.
// Ports   : clk_i, rst_ni (async, active low)
//           req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i/req_be_i
//           rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_write_o
//           sram_req_o/sram_we_o/sram_addr_o/sram_wdata_o/sram_be_o/sram_rdata_i
// Macro   : SRAM_ADAPTER_WRITE_ACK_EN -- writes take a credit and return an
//           ordered ack (rsp_write_o=1, rdata 0). Undefined: writes are silent
//           and rsp_write_o is 0.
module sram_stream_adapter
  import sram_adapter_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int unsigned RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int unsigned BE_WIDTH   = ceil_div(DATA_WIDTH, BYTE_WIDTH),
  parameter type addr_t = logic [$clog2(NUM_WORDS)-1:0],
  parameter type data_t = logic [DATA_WIDTH-1:0],
  parameter type strb_t = logic [BE_WIDTH-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req_valid_i,
  output logic  req_ready_o,
  input  logic  req_we_i,
  input  addr_t req_addr_i,
  input  data_t req_wdata_i,
  input  strb_t req_be_i,
  output logic  rsp_valid_o,
  input  logic  rsp_ready_i,
  output data_t rsp_rdata_o,
  output logic  rsp_write_o,
  output logic  sram_req_o,
  output logic  sram_we_o,
  output addr_t sram_addr_o,
  output data_t sram_wdata_o,
  output strb_t sram_be_o,
  input  data_t sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    data_t rdata;
    logic  write;
  } rsp_entry_t;

  logic [CNT_W-1:0] credit_q;
  logic             inflight_q;
  logic             accept, take_credit, pop;
  logic             buf_empty, buf_push, buf_pop;
  rsp_entry_t       new_rsp, head_rsp, out_rsp;

  // Ready depends on registered state only, so no combinational path from
  // the response side back into the request side.
  assign req_ready_o = (credit_q < CNT_W'(RSP_DEPTH));
  assign accept      = req_valid_i & req_ready_o;

  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
  logic inflight_wr_q;

  assign take_credit   = accept;
  assign new_rsp.rdata = inflight_wr_q ? '0 : sram_rdata_i;
  assign new_rsp.write = inflight_wr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_wr_q <= 1'b0;
    else         inflight_wr_q <= accept & req_we_i;
  end
`else
  assign take_credit   = accept & ~req_we_i;
  assign new_rsp.rdata = sram_rdata_i;
  assign new_rsp.write = 1'b0;
`endif

  // Data arriving this cycle bypasses the buffer only when nothing older is
  // queued; otherwise it goes to the tail to keep responses in order.
  assign rsp_valid_o = inflight_q | ~buf_empty;
  assign out_rsp     = buf_empty ? new_rsp : head_rsp;
  assign rsp_rdata_o = out_rsp.rdata;
  assign rsp_write_o = out_rsp.write;

  assign pop      = rsp_valid_o & rsp_ready_i;
  assign buf_push = inflight_q & ~(buf_empty & rsp_ready_i);
  assign buf_pop  = pop & ~buf_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      credit_q   <= credit_q + CNT_W'(take_credit) - CNT_W'(pop);
      inflight_q <= take_credit;
    end
  end

  sram_adapter_rsp_buf #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (buf_push),
    .data_i  (new_rsp),
    .pop_i   (buf_pop),
    .empty_o (buf_empty),
    .head_o  (head_rsp)
  );

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Bench for sram_stream_adapter with a behavioural SRAM and an in-order
// response scoreboard; handles both builds of SRAM_ADAPTER_WRITE_ACK_EN.
module tb_sram_stream_adapter;

  localparam int RSP_DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [9:0]  req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_be_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [63:0] rsp_rdata_o;
  logic        sram_req_o, sram_we_o;
  logic [9:0]  sram_addr_o;
  logic [63:0] sram_wdata_o, sram_rdata_i;
  logic [7:0]  sram_be_o;

  sram_stream_adapter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_write_o  (rsp_write_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM: 1-cycle read latency, rdata holds last read word.
  logic [63:0] sram_mem [1024];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        wr;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_mem [1024];
  int          n_vec = 0, n_err = 0;
  int          n_acc = 0, n_rsp = 0, n_stall = 0;
  logic [63:0] last_rd;
  logic        hold_q = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on response handshake, push on request accept.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) chk("rsp_hold", rsp_valid_o, 1'b1);
      if (rsp_valid_o && rsp_ready_i) begin
        n_rsp++;
        if (sb_q.size() == 0) chk("unexp_rsp", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.data);
          chk("rsp_write", rsp_write_o, e.wr);
          if (!e.wr) last_rd = rsp_rdata_o;
        end
      end
      hold_q = rsp_valid_o & ~rsp_ready_i;
      if (req_valid_i && req_ready_o) begin
        n_acc++;
        if (!req_we_i) sb_q.push_back('{ref_mem[req_addr_i], 1'b0});
        else begin
          for (int b = 0; b < 8; b++)
            if (req_be_i[b]) ref_mem[req_addr_i][b*8 +: 8] = req_wdata_i[b*8 +: 8];
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
          sb_q.push_back('{64'h0, 1'b1});
`endif
        end
      end
    end
  end

  task automatic issue(input logic we, input int addr, input logic [63:0] wd, input logic [7:0] be);
    bit got = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr[9:0];
    req_wdata_i = wd;
    req_be_i    = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin got = 1; break; end
      n_stall++;
    end
    if (!got) chk("req_timeout", 1'b0, 1'b1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk_i);
    chk("drain_left", sb_q.size(), 0);
    @(posedge clk_i); #1;
  endtask

  int base;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 64'h0;
      ref_mem[i]  = 64'h0;
    end
    sram_rdata_i = 64'h0;
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0;   req_be_i = '0;   rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_sram_req",  sram_req_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: write then read, one-cycle latency
    issue(1'b1, 5, 64'hDEAD, 8'hFF);
    issue(1'b0, 5, 64'h0, 8'h00);
    @(negedge clk_i);
    chk("t1_valid", rsp_valid_o, 1'b1);
    chk("t1_rdata", rsp_rdata_o, 64'hDEAD);
    drain();

    // 2: back-to-back reads with rsp_ready_i=1
    for (int i = 0; i < 8; i++) issue(1'b1, i, 64'h1000 + 64'(i * 3), 8'hFF);
    drain();
    base = n_rsp;
    n_stall = 0;
    for (int i = 0; i < 8; i++) issue(1'b0, i, 64'h0, 8'h00);
    drain();
    chk("t2_stalls", n_stall, 0);
    chk("t2_rsp_cnt", n_rsp - base, 8);
    chk("t2_last", last_rd, 64'h1015);

    // 3: backpressure -> exactly RSP_DEPTH accepted
    rsp_ready_i = 1'b0;
    base = n_acc;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      req_addr_i = req_addr_i + 10'd1;
    end
    req_valid_i = 1'b0;
    chk("t3_accepted", n_acc - base, RSP_DEPTH);
    chk("t3_ready_low", req_ready_o, 1'b0);
    rsp_ready_i = 1'b1;
    drain();
    chk("t3_ready_back", req_ready_o, 1'b1);

    // 4: partial byte-enable write
    issue(1'b1, 20, 64'h1122334455667788, 8'hFF);
    issue(1'b1, 20, 64'h00000000000000FF, 8'h01);
    issue(1'b0, 20, 64'h0, 8'h00);
    drain();
    chk("t4_merge", last_rd, 64'h11223344556677FF);

    // 5: read then write same address next cycle
    issue(1'b1, 30, 64'hAAAA, 8'hFF);
    issue(1'b0, 30, 64'h0, 8'h00);
    issue(1'b1, 30, 64'hBBBB, 8'hFF);
    drain();
    chk("t5_old", last_rd, 64'hAAAA);
    issue(1'b0, 30, 64'h0, 8'h00);
    drain();
    chk("t5_new", last_rd, 64'hBBBB);

    // 6: reset with two buffered responses
    rsp_ready_i = 1'b0;
    issue(1'b0, 5, 64'h0, 8'h00);
    issue(1'b0, 20, 64'h0, 8'h00);
    @(posedge clk_i); #2;
    chk("t6_pre_valid", rsp_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid_o, 1'b0);
    chk("t6_rst_ready", req_ready_o, 1'b1);
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    base = n_rsp;
    repeat (5) @(negedge clk_i);
    chk("t6_no_stale", n_rsp - base, 0);
    @(posedge clk_i); #1;

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
    // write ack consumes a credit
    rsp_ready_i = 1'b0;
    issue(1'b1, 40, 64'h55, 8'hFF);
    @(negedge clk_i);
    chk("wack_valid", rsp_valid_o, 1'b1);
    chk("wack_flag", rsp_write_o, 1'b1);
    chk("wack_rdata", rsp_rdata_o, 64'h0);
    issue(1'b1, 41, 64'h66, 8'hFF);
    @(negedge clk_i);
    chk("wack_credits", req_ready_o, 1'b0);
    rsp_ready_i = 1'b1;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
